// File: rtl/mac_pkg.sv
// mac_pkg: shared constants and arithmetic helpers for the MAC accumulator.
// The helpers work on 64-bit signed values with the target width passed in,
// so one function serves any accumulator width up to 62 bits.
package mac_pkg;

    localparam int MULT_LATENCY = 8;
    localparam int PROD_W_DEF   = 16;
    localparam int ACC_W_DEF    = 24;
    localparam int CNT_W_DEF    = 8;

    // Largest representable value of a w-bit two's-complement number.
    function automatic logic signed [63:0] acc_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest representable value of a w-bit two's-complement number.
    function automatic logic signed [63:0] acc_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    localparam logic signed [63:0] ACC_MAX_DEF = acc_max(ACC_W_DEF);
    localparam logic signed [63:0] ACC_MIN_DEF = acc_min(ACC_W_DEF);

    // Sign-extend the low w bits of v to 64 bits.
    function automatic logic signed [63:0] sext(input logic [63:0] v, input int w);
        logic signed [63:0] t;
        t = v << (64 - w);
        return t >>> (64 - w);
    endfunction

    // Add two w-bit values; when clamp_en, clamp into the w-bit range and flag it.
    // Without clamping the caller truncates to w bits, giving wrap-around.
    function automatic logic signed [63:0] sat_add(
        input  logic signed [63:0] a,
        input  logic signed [63:0] b,
        input  int                 w,
        input  logic               clamp_en,
        output logic               clamped
    );
        logic signed [63:0] s;
        s       = a + b;
        clamped = 1'b0;
        if (clamp_en && (s > acc_max(w))) begin
            s       = acc_max(w);
            clamped = 1'b1;
        end else if (clamp_en && (s < acc_min(w))) begin
            s       = acc_min(w);
            clamped = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/valid_delay.sv
// valid_delay: LATENCY-deep shift register carrying {valid, last} alongside a
// pipeline that has no control bits of its own. last is masked by valid on
// entry so a stray last without valid never reaches the tap.
module valid_delay #(
    parameter int LATENCY = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_i,
    input  logic last_i,
    output logic valid_o,
    output logic last_o
);

    logic [LATENCY-1:0] v_q;
    logic [LATENCY-1:0] l_q;

    // Shift valid/last one stage per clock; reset flushes everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            l_q <= '0;
        end else begin
            v_q[0] <= valid_i;
            l_q[0] <= valid_i & last_i;
            for (int i = 1; i < LATENCY; i++) begin
                v_q[i] <= v_q[i-1];
                l_q[i] <= l_q[i-1];
            end
        end
    end

    assign valid_o = v_q[LATENCY-1];
    assign last_o  = l_q[LATENCY-1];

endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums the signed products of each group coming out of a
// fixed-latency multiplier and presents one result per group in a
// valid/ready output register. Build option MAC_SAT_EN: clamp each addition
// to the accumulator range and report clamping via out_sat; without it the
// sum wraps and out_sat is 0.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int LATENCY = MULT_LATENCY,
    parameter int PROD_W  = PROD_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [PROD_W-1:0] product,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat,
    output logic              overrun
);

`ifdef MAC_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    logic                     dv;
    logic                     dl;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  base_d;
    logic        [CNT_W-1:0]  cnt_q;
    logic        [CNT_W-1:0]  cnt_d;
    logic                     first_q;
    logic                     clamped;
    logic signed [63:0]       sum64;
    logic                     out_valid_q;
    logic        [ACC_W-1:0]  out_acc_q;
    logic        [CNT_W-1:0]  out_count_q;
    logic                     overrun_q;
    logic                     unused_hi;

    // dv/dl line up with the multiplier output for the same operands.
    valid_delay #(.LATENCY(LATENCY)) u_delay (
        .clk     (clk),
        .rst     (rst),
        .valid_i (in_valid),
        .last_i  (in_last),
        .valid_o (dv),
        .last_o  (dl)
    );

    // Next running sum and count; a group start ignores the stale accumulator.
    always_comb begin
        base_d  = first_q ? '0 : acc_q;
        clamped = 1'b0;
        sum64   = sat_add(sext(64'(base_d), ACC_W), sext(64'(product), PROD_W),
                          ACC_W, SAT_EN, clamped);
        acc_d   = sum64[ACC_W-1:0];
        cnt_d   = first_q ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
    end

    assign unused_hi = ^sum64[63:ACC_W];

    // Group state and output register; a new result beats a same-cycle transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_count_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            if (dv) begin
                acc_q   <= acc_d;
                cnt_q   <= cnt_d;
                first_q <= dl;
            end
            if (dv && dl) begin
                out_valid_q <= 1'b1;
                out_acc_q   <= acc_d;
                out_count_q <= cnt_d;
                if (out_valid_q && !out_ready)
                    overrun_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef MAC_SAT_EN
    logic sat_q;
    logic sat_d;
    logic out_sat_q;

    assign sat_d = (~first_q & sat_q) | clamped;

    // Sticky clamp flag per group, latched into the output with the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q     <= 1'b0;
            out_sat_q <= 1'b0;
        end else if (dv) begin
            sat_q <= sat_d;
            if (dl)
                out_sat_q <= sat_d;
        end
    end

    assign out_sat = out_sat_q;
`else
    logic unused_clamped;
    assign unused_clamped = clamped;
    assign out_sat        = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_count = out_count_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: multiplier modelled as an 8-deep product pipe,
// group-level reference model, table of groups plus hand-written corners and
// a randomized run. A second instance with ACC_W=16 covers saturation/wrap.
module tb_mac_accumulator;

    localparam int L  = 8;
    localparam int AW = 24;

    logic clk = 1'b0;
    logic rst, in_valid, in_last, out_ready;
    logic signed [7:0] a, b;
    logic [15:0] product;
    logic [15:0] mp [L];

    logic          out_valid, out_sat, overrun;
    logic [AW-1:0] out_acc;
    logic [7:0]    out_count;
    logic          v16, sat16, ovr16;
    logic [15:0]   acc16;
    logic [7:0]    cnt16;

    always #5 clk = ~clk;

    // Multiplier stand-in: product of operands presented before edge n appears after edge n+L-1.
    always @(posedge clk) begin
        mp[0] <= a * b;
        for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
    end
    assign product = mp[L-1];

    mac_accumulator #(.LATENCY(L), .PROD_W(16), .ACC_W(AW), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .product(product),
        .out_ready(out_ready), .out_valid(out_valid), .out_acc(out_acc),
        .out_count(out_count), .out_sat(out_sat), .overrun(overrun));

    mac_accumulator #(.LATENCY(L), .PROD_W(16), .ACC_W(16), .CNT_W(8)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .product(product),
        .out_ready(out_ready), .out_valid(v16), .out_acc(acc16),
        .out_count(cnt16), .out_sat(sat16), .overrun(ovr16));

    int n_chk = 0;
    int n_fail = 0;

    function automatic void chk(string nm, logic signed [63:0] act, logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model (group level) ----------------
    typedef struct { int due; longint acc; int cnt; bit sat; } res_t;
    res_t   pend[$];
    int     edge_n = 0;
    longint g_acc = 0;
    int     g_cnt = 0;
    bit     g_first = 1, g_sat = 0;
    bit     m_v = 0, m_sat = 0, m_ovr = 0;
    longint m_acc = 0;
    int     m_cnt = 0;

    // Bring s back into a w-bit signed range: clamp or wrap depending on build.
    function automatic longint fold(longint s, int w, output bit c);
        longint span, half;
        span = longint'(1) << w;
        half = span / 2;
        c = 0;
`ifdef MAC_SAT_EN
        if (s > half - 1) begin c = 1; return half - 1; end
        if (s < -half)    begin c = 1; return -half; end
        return s;
`else
        s = ((s % span) + span) % span;
        return (s >= half) ? s - span : s;
`endif
    endfunction

    task automatic tick();
        bit c;
        res_t r;
        @(posedge clk);
        edge_n++;
        if (rst) begin
            pend.delete();
            g_acc = 0; g_cnt = 0; g_first = 1; g_sat = 0;
            m_v = 0; m_acc = 0; m_cnt = 0; m_sat = 0; m_ovr = 0;
        end else begin
            if (pend.size() > 0 && pend[0].due == edge_n) begin
                r = pend.pop_front();
                if (m_v && !out_ready) m_ovr = 1;
                m_v = 1; m_acc = r.acc; m_cnt = r.cnt; m_sat = r.sat;
            end else if (m_v && out_ready) begin
                m_v = 0;
            end
            if (in_valid) begin
                if (g_first) begin g_acc = 0; g_cnt = 0; g_sat = 0; end
                g_acc = fold(g_acc + longint'(int'(a) * int'(b)), AW, c);
                g_sat |= c;
                g_cnt = (g_cnt >= 255) ? 255 : g_cnt + 1;
                g_first = 0;
                if (in_last) begin
                    r.due = edge_n + L; r.acc = g_acc; r.cnt = g_cnt; r.sat = g_sat;
                    pend.push_back(r);
                    g_first = 1;
                end
            end
        end
        @(negedge clk);
        chk("valid", out_valid, m_v);
        chk("acc", $signed(out_acc), m_acc);
        chk("count", out_count, m_cnt);
        chk("sat", out_sat, m_sat);
        chk("overrun", overrun, m_ovr);
    endtask

    task automatic idle();
        in_valid = 0; in_last = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
    endtask

    task automatic elem(input int x, input int y, input bit last);
        in_valid = 1; in_last = last; a = 8'(x); b = 8'(y);
        tick();
    endtask

    typedef struct { int n; bit gap; int av[4]; int bv[4]; longint eacc; int ecnt; } vec_t;
    vec_t vecs[5];

    initial begin
        vecs[0] = '{4, 0, '{3, -5, 7, -8},       '{4, 6, -2, -8},     32,     4};
        vecs[1] = '{1, 0, '{-128, 0, 0, 0},      '{-128, 0, 0, 0},    16384,  1};
        vecs[2] = '{1, 1, '{1, 0, 0, 0},         '{1, 0, 0, 0},       1,      1};
        vecs[3] = '{3, 1, '{-128, -128, -128, 0}, '{127, 127, 127, 0}, -48768, 3};
        vecs[4] = '{2, 0, '{127, 127, 0, 0},     '{127, 127, 0, 0},   32258,  2};

        // Reset
        rst = 1; out_ready = 1; idle();
        repeat (3) tick();
        rst = 0;
        chk("rst_valid", out_valid, 0);
        chk("rst_acc", out_acc, 0);
        chk("rst_count", out_count, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst_overrun", overrun, 0);

        // Table of groups, out_ready held high
        for (int t = 0; t < 5; t++) begin
            for (int e = 0; e < vecs[t].n; e++) begin
                if (vecs[t].gap) begin idle(); tick(); tick(); end
                elem(vecs[t].av[e], vecs[t].bv[e], e == vecs[t].n - 1);
            end
            idle();
            for (int k = 1; k <= L; k++) begin
                tick();
                chk("tbl_valid_timing", out_valid, k == L);
            end
            chk("tbl_acc", $signed(out_acc), vecs[t].eacc);
            chk("tbl_count", out_count, vecs[t].ecnt);
            tick();
            chk("tbl_valid_drop", out_valid, 0);
        end

        // Count saturates at all-ones
        for (int e = 0; e < 260; e++) elem(1, 1, e == 259);
        idle();
        repeat (L) tick();
        chk("cntsat_valid", out_valid, 1);
        chk("cntsat_count", out_count, 255);
        chk("cntsat_acc", $signed(out_acc), 260);

        // Back-to-back results with no ready: overwrite and sticky overrun
        tick();
        out_ready = 0;
        elem(2, 5, 1);
        elem(3, -4, 1);
        idle();
        repeat (L) tick();
        chk("ovr_acc", $signed(out_acc), -12);
        chk("ovr_flag", overrun, 1);
        out_ready = 1;
        repeat (3) tick();
        chk("ovr_sticky", overrun, 1);
        chk("ovr_valid_drop", out_valid, 0);

        // Reset while a group is in flight
        elem(1, 1, 0);
        elem(1, 1, 1);
        idle(); tick(); tick();
        rst = 1; tick(); rst = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("rstmid_no_valid", out_valid, 0);
        end
        chk("rstmid_overrun_clr", overrun, 0);
        elem(2, 3, 1);
        idle();
        repeat (L) tick();
        chk("rstmid_valid", out_valid, 1);
        chk("rstmid_acc", $signed(out_acc), 6);
        chk("rstmid_count", out_count, 1);

        // 16-bit accumulator: three (-128)*(-128)
        rst = 1; tick(); rst = 0;
        for (int e = 0; e < 3; e++) elem(-128, -128, e == 2);
        idle();
        repeat (L) tick();
        chk("acc16_valid", v16, 1);
        chk("acc16_count", cnt16, 3);
`ifdef MAC_SAT_EN
        chk("acc16_acc", $signed(acc16), 32767);
        chk("acc16_sat", sat16, 1);
`else
        chk("acc16_acc", $signed(acc16), -16384);
        chk("acc16_sat", sat16, 0);
`endif

        // Randomized run against the model
        for (int i = 0; i < 800; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_last   = ($urandom_range(0, 9) < 3);
            a         = ($urandom_range(0, 7) == 0) ? -8'sd128 : 8'($urandom);
            b         = 8'($urandom);
            out_ready = 1'($urandom);
            tick();
        end
        rst = 0; idle(); out_ready = 1;
        repeat (L + 2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
